// File: rtl/gate_delay_sequencer.sv
// Gate/delay pulse sequencer: on each external trigger, walks a programmable step table and
// fires one pulse channel per step. Define GDS_WATCHDOG_EN to add the WAIT-state watchdog.
module gate_delay_sequencer #(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned CW       = 32,
    parameter int unsigned WDOG_CYC = 4096
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_trigger,
    input  logic                     i_abort,
    input  logic                     i_cfg_we,
    input  logic [$clog2(DEPTH)-1:0] i_cfg_addr,
    input  logic [$clog2(N_CH)-1:0]  i_cfg_ch,
    input  logic [CW-1:0]            i_cfg_delay,
    input  logic [CW-1:0]            i_cfg_width,
    input  logic [$clog2(DEPTH):0]   i_n_steps,
    input  logic [15:0]              i_repeat,
    input  logic [N_CH-1:0]          i_ch_busy,
    output logic [N_CH-1:0]          o_ch_trig,
    output logic [N_CH*CW-1:0]       o_ch_delay,
    output logic [N_CH*CW-1:0]       o_ch_width,
    output logic [$clog2(DEPTH)-1:0] o_step,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned CHW = $clog2(N_CH);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFire,
        StWaitHi,
        StWaitLo,
        StNext
    } state_e;

    state_e                  state_q;
    logic [AW-1:0]           step_q;
    logic [AW:0]             n_steps_q;
    logic [15:0]             repeat_q;
    logic [15:0]             pass_q;
    logic [CHW-1:0]          cur_ch_q;
    logic [N_CH-1:0]         ch_trig_q;
    logic [N_CH-1:0][CW-1:0] ch_delay_q;
    logic [N_CH-1:0][CW-1:0] ch_width_q;
    logic                    busy_q;
    logic                    done_q;

    logic [CHW-1:0]          tbl_ch_q    [DEPTH];
    logic [CW-1:0]           tbl_delay_q [DEPTH];
    logic [CW-1:0]           tbl_width_q [DEPTH];

    logic                    trig_s1_q;
    logic                    trig_s2_q;
    logic                    trig_s3_q;
    logic                    trig_ev_q;

    logic [AW:0]             n_steps_clamped;
    logic [AW:0]             step_inc;
    logic                    cur_busy;

    assign n_steps_clamped = (i_n_steps > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : i_n_steps;
    assign step_inc        = {1'b0, step_q} + (AW+1)'(1);
    assign cur_busy        = i_ch_busy[cur_ch_q];

`ifdef GDS_WATCHDOG_EN
    localparam int unsigned WW = $clog2(WDOG_CYC + 1);

    logic [WW-1:0] wdog_q;
    logic          err_q;
    logic          wdog_hit;

    assign wdog_hit = ((state_q == StWaitHi) || (state_q == StWaitLo)) &&
                      (wdog_q == WW'(WDOG_CYC - 1));
    assign o_err    = err_q;
`else
    assign o_err    = 1'b0;
`endif

    // Two-flop synchroniser followed by a rising-edge detector.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_s3_q <= 1'b0;
            trig_ev_q <= 1'b0;
        end else begin
            trig_s1_q <= i_trigger;
            trig_s2_q <= trig_s1_q;
            trig_s3_q <= trig_s2_q;
            trig_ev_q <= trig_s2_q & ~trig_s3_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_ch_q[i]    <= '0;
                tbl_delay_q[i] <= '0;
                tbl_width_q[i] <= '0;
            end
        end else if (i_cfg_we && (state_q == StIdle)) begin
            tbl_ch_q[i_cfg_addr]    <= i_cfg_ch;
            tbl_delay_q[i_cfg_addr] <= i_cfg_delay;
            tbl_width_q[i_cfg_addr] <= i_cfg_width;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= StIdle;
            step_q     <= '0;
            n_steps_q  <= '0;
            repeat_q   <= '0;
            pass_q     <= '0;
            cur_ch_q   <= '0;
            ch_trig_q  <= '0;
            ch_delay_q <= '0;
            ch_width_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef GDS_WATCHDOG_EN
            wdog_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            ch_trig_q <= '0;
            done_q    <= 1'b0;
            if (i_abort) begin
                state_q <= StIdle;
                step_q  <= '0;
                busy_q  <= 1'b0;
            end
`ifdef GDS_WATCHDOG_EN
            else if (wdog_hit) begin
                state_q <= StIdle;
                step_q  <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
            end
`endif
            else begin
                unique case (state_q)
                    StIdle: begin
                        // Events arriving outside IDLE never reach here, so they are dropped.
                        if (trig_ev_q && (n_steps_clamped != '0)) begin
                            state_q   <= StLoad;
                            busy_q    <= 1'b1;
                            step_q    <= '0;
                            pass_q    <= '0;
                            n_steps_q <= n_steps_clamped;
                            repeat_q  <= i_repeat;
`ifdef GDS_WATCHDOG_EN
                            err_q     <= 1'b0;
`endif
                        end
                    end
                    StLoad: begin
                        cur_ch_q                   <= tbl_ch_q[step_q];
                        ch_delay_q[tbl_ch_q[step_q]] <= tbl_delay_q[step_q];
                        ch_width_q[tbl_ch_q[step_q]] <= tbl_width_q[step_q];
                        state_q                    <= StFire;
                    end
                    StFire: begin
                        ch_trig_q[cur_ch_q] <= 1'b1;
                        state_q             <= StWaitHi;
`ifdef GDS_WATCHDOG_EN
                        wdog_q              <= '0;
`endif
                    end
                    StWaitHi: begin
                        if (cur_busy) state_q <= StWaitLo;
`ifdef GDS_WATCHDOG_EN
                        wdog_q <= wdog_q + 1'b1;
`endif
                    end
                    StWaitLo: begin
                        if (!cur_busy) state_q <= StNext;
`ifdef GDS_WATCHDOG_EN
                        wdog_q <= wdog_q + 1'b1;
`endif
                    end
                    StNext: begin
                        if (step_inc < n_steps_q) begin
                            step_q  <= step_inc[AW-1:0];
                            state_q <= StLoad;
                        end else if (pass_q < repeat_q) begin
                            // pass_q tops out at repeat_q, so 16'hFFFF cannot wrap.
                            pass_q  <= pass_q + 16'd1;
                            step_q  <= '0;
                            state_q <= StLoad;
                        end else begin
                            step_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ch_trig  = ch_trig_q;
    assign o_ch_delay = ch_delay_q;
    assign o_ch_width = ch_width_q;
    assign o_step     = step_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_gate_delay_sequencer.sv
// Scoreboard bench for gate_delay_sequencer: a step-table model predicts every channel pulse
// and sequence end; a monitor pops and compares as the DUT presents them.
module tb_gate_delay_sequencer;
    localparam int N_CH  = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 32;
    localparam int WDOG  = 64;
    localparam int VW    = N_CH * CW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            trigger = 1'b0;
    logic            abort = 1'b0;
    logic            cfg_we = 1'b0;
    logic [2:0]      cfg_addr = '0;
    logic [1:0]      cfg_ch = '0;
    logic [CW-1:0]   cfg_delay = '0;
    logic [CW-1:0]   cfg_width = '0;
    logic [3:0]      n_steps = '0;
    logic [15:0]     rep = '0;
    logic [N_CH-1:0] ch_busy;
    logic [N_CH-1:0] resp_busy = '0;
    logic [N_CH-1:0] man_busy = '0;
    bit              auto_busy = 1'b1;

    logic [N_CH-1:0] ch_trig;
    logic [VW-1:0]   ch_delay;
    logic [VW-1:0]   ch_width;
    logic [2:0]      step;
    logic            busy;
    logic            done;
    logic            err;

    assign ch_busy = auto_busy ? resp_busy : man_busy;

    gate_delay_sequencer #(
        .N_CH    (N_CH),
        .DEPTH   (DEPTH),
        .CW      (CW),
        .WDOG_CYC(WDOG)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_trigger  (trigger),
        .i_abort    (abort),
        .i_cfg_we   (cfg_we),
        .i_cfg_addr (cfg_addr),
        .i_cfg_ch   (cfg_ch),
        .i_cfg_delay(cfg_delay),
        .i_cfg_width(cfg_width),
        .i_n_steps  (n_steps),
        .i_repeat   (rep),
        .i_ch_busy  (ch_busy),
        .o_ch_trig  (ch_trig),
        .o_ch_delay (ch_delay),
        .o_ch_width (ch_width),
        .o_step     (step),
        .o_busy     (busy),
        .o_done     (done),
        .o_err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;

    task automatic chkv(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: step table contents and what each channel's regs should hold.
    typedef struct {
        bit            is_done;
        int            ch;
        int            stp;
        logic [VW-1:0] dv;
        logic [VW-1:0] wv;
    } exp_t;

    exp_t          q[$];
    int            m_ch[DEPTH] = '{default: 0};
    logic [CW-1:0] m_d[DEPTH]  = '{default: '0};
    logic [CW-1:0] m_w[DEPTH]  = '{default: '0};
    logic [VW-1:0] m_dv = '0;
    logic [VW-1:0] m_wv = '0;
    logic [VW-1:0] seen_dv = '0;
    logic [VW-1:0] seen_wv = '0;
    int            n_trig = 0;
    int            n_done = 0;
    int            last_trig_cyc = 0;

    function automatic void expect_run(input int ns, input int reps);
        exp_t e;
        int   n = (ns > DEPTH) ? DEPTH : ns;
        if (n == 0) return;
        for (int p = 0; p <= reps; p++) begin
            for (int s = 0; s < n; s++) begin
                m_dv[m_ch[s]*CW +: CW] = m_d[s];
                m_wv[m_ch[s]*CW +: CW] = m_w[s];
                e.is_done = 1'b0;
                e.ch      = m_ch[s];
                e.stp     = s;
                e.dv      = m_dv;
                e.wv      = m_wv;
                q.push_back(e);
            end
        end
        e.is_done = 1'b1;
        q.push_back(e);
    endfunction

    // Sequence cut short: only the loads already observed took effect.
    task automatic flush_model();
        q.delete();
        m_dv = seen_dv;
        m_wv = seen_wv;
    endtask

    initial begin : monitor
        exp_t            e;
        logic [N_CH-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst && ch_trig != '0) begin
                n_trig++;
                last_trig_cyc = cyc;
                if (q.size() == 0 || q[0].is_done) begin
                    chki("unexpected_trig", int'(ch_trig), 0);
                end else begin
                    e = q.pop_front();
                    oh = '0;
                    oh[e.ch] = 1'b1;
                    chki("trig_ch", int'(ch_trig), int'(oh));
                    chki("trig_step", int'(step), e.stp);
                    chkv("trig_delay", ch_delay, e.dv);
                    chkv("trig_width", ch_width, e.wv);
                    chki("trig_busy", int'(busy), 1);
                    seen_dv = e.dv;
                    seen_wv = e.wv;
                end
            end
            if (!rst && done) begin
                n_done++;
                if (q.size() == 0 || !q[0].is_done) begin
                    chki("unexpected_done", int'(done), 0);
                end else begin
                    e = q.pop_front();
                    chki("done_busy", int'(busy), 0);
                end
            end
        end
    end

    // Channel model: busy rises after a short random latency and stays up a few cycles.
    initial begin : responder
        int c;
        int lat;
        int hold;
        c = 0;
        forever begin
            @(negedge clk);
            if (auto_busy && !rst && ch_trig != '0) begin
                for (int i = 0; i < N_CH; i++) if (ch_trig[i]) c = i;
                lat  = $urandom_range(0, 3);
                hold = $urandom_range(1, 5);
                repeat (lat) @(posedge clk);
                #2 resp_busy[c] = 1'b1;
                repeat (hold) @(posedge clk);
                #2 resp_busy[c] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_write(input int a, input int c, input logic [CW-1:0] d,
                             input logic [CW-1:0] w, input bit upd);
        cfg_addr  = 3'(a);
        cfg_ch    = 2'(c);
        cfg_delay = d;
        cfg_width = w;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
        if (upd) begin
            m_ch[a] = c;
            m_d[a]  = d;
            m_w[a]  = w;
        end
    endtask

    task automatic fire_trigger();
        trigger = 1'b1;
        repeat (3) tick();
        trigger = 1'b0;
    endtask

    task automatic wait_trigs(input int target, input int budget);
        int k = 0;
        while (n_trig < target && k < budget) begin
            tick();
            k++;
        end
        chki("wait_trig_reached", int'(n_trig >= target), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            tick();
            k++;
        end
        chki("wait_done_reached", int'(n_done >= target), 1);
    endtask

    task automatic run(input int ns, input int reps);
        int d0 = n_done;
        n_steps = 4'(ns);
        rep     = 16'(reps);
        expect_run(ns, reps);
        fire_trigger();
        wait_done(d0 + 1, (reps + 1) * DEPTH * 25 + 50);
        tick();
        chki("run_queue_empty", q.size(), 0);
    endtask

    initial begin : watchdog_timer
        #900000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int t0;
        int base;
        int d0;
        int busy_seen;

        repeat (3) @(posedge clk);
        #2;
        chki("rst_trig", int'(ch_trig), 0);
        chkv("rst_delay", ch_delay, '0);
        chkv("rst_width", ch_width, '0);
        chki("rst_step", int'(step), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_done", int'(done), 0);
        chki("rst_err", int'(err), 0);
        rst = 1'b0;
        tick();

        // Single step on channel 2, latency from first sampling edge.
        cfg_write(0, 2, 32'd10, 32'd5, 1'b1);
        n_steps = 4'd1;
        rep     = 16'd0;
        expect_run(1, 0);
        t0 = cyc + 1;
        fire_trigger();
        wait_done(1, 200);
        chki("trig_latency", last_trig_cyc - t0, 5);
        chki("t1_delay_ch2", int'(ch_delay[2*CW +: CW]), 10);
        chki("t1_width_ch2", int'(ch_width[2*CW +: CW]), 5);
        chki("t1_queue_empty", q.size(), 0);

        // Three steps, one repeat; a mid-run trigger and table write must be ignored.
        cfg_write(0, 0, $urandom(), $urandom(), 1'b1);
        cfg_write(1, 1, $urandom(), $urandom(), 1'b1);
        cfg_write(2, 3, $urandom(), $urandom(), 1'b1);
        base = n_trig;
        d0   = n_done;
        n_steps = 4'd3;
        rep     = 16'd1;
        expect_run(3, 1);
        fire_trigger();
        wait_trigs(base + 1, 100);
        fire_trigger();
        cfg_write(0, 3, 32'hDEAD, 32'hBEEF, 1'b0);
        wait_done(d0 + 1, 400);
        repeat (10) tick();
        chki("t2_trig_count", n_trig - base, 6);
        chki("t2_single_done", n_done - d0, 1);
        chki("t2_queue_empty", q.size(), 0);
        run(1, 0);

        // Abort while step 1 waits for busy to fall, then restart from step 0.
        auto_busy = 1'b0;
        man_busy  = '0;
        base = n_trig;
        d0   = n_done;
        n_steps = 4'd3;
        rep     = 16'd0;
        expect_run(3, 0);
        fire_trigger();
        wait_trigs(base + 1, 50);
        man_busy[0] = 1'b1;
        repeat (2) tick();
        man_busy[0] = 1'b0;
        wait_trigs(base + 2, 50);
        man_busy[1] = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chki("abort_busy", int'(busy), 0);
        chki("abort_step", int'(step), 0);
        flush_model();
        man_busy = '0;
        repeat (10) tick();
        chki("abort_no_done", n_done - d0, 0);
        chkv("abort_delay_held", ch_delay, seen_dv);
        auto_busy = 1'b1;
        run(3, 0);

        // Disarmed: no sequence, no pulses.
        base = n_trig;
        busy_seen = 0;
        n_steps = 4'd0;
        fire_trigger();
        repeat (15) begin
            tick();
            if (busy) busy_seen++;
        end
        chki("nsteps0_busy", busy_seen, 0);
        chki("nsteps0_trig", n_trig - base, 0);

        // Step count beyond the table clamps to the full table.
        for (int a = 0; a < DEPTH; a++) cfg_write(a, $urandom_range(0, 3), $urandom(), $urandom(), 1'b1);
        run(15, 0);

        // Table write landing on the same cycle the trigger event reaches the FSM.
        n_steps = 4'd1;
        rep     = 16'd0;
        d0      = n_done;
        trigger = 1'b1;
        repeat (3) tick();
        cfg_write(0, 1, 32'h1234_5678, 32'h0000_0042, 1'b1);
        trigger = 1'b0;
        expect_run(1, 0);
        wait_done(d0 + 1, 100);
        tick();
        chki("wr_trig_queue_empty", q.size(), 0);

        // Randomised tables, step counts and repeats.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++)
                cfg_write(a, $urandom_range(0, 3), $urandom(), $urandom(), 1'b1);
            run(((it % 3) == 2) ? $urandom_range(9, 15) : $urandom_range(1, 8),
                $urandom_range(0, 2));
        end

        // Channel never reports busy.
        auto_busy = 1'b0;
        man_busy  = '0;
        base = n_trig;
        d0   = n_done;
        n_steps = 4'd1;
        rep     = 16'd0;
        expect_run(1, 0);
        fire_trigger();
        wait_trigs(base + 1, 50);
`ifdef GDS_WATCHDOG_EN
        wait_done(d0 + 1, WDOG + 20);
        chki("wdog_err", int'(err), 1);
        chki("wdog_busy", int'(busy), 0);
`else
        repeat (100) tick();
        chki("stuck_busy", int'(busy), 1);
        chki("stuck_no_done", n_done - d0, 0);
        chki("stuck_err", int'(err), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chki("stuck_abort_busy", int'(busy), 0);
        flush_model();
`endif
        auto_busy = 1'b1;
        repeat (3) tick();

        // Asynchronous reset in the middle of a sequence.
        for (int a = 0; a < 3; a++) cfg_write(a, a, $urandom() | 32'h1, $urandom() | 32'h1, 1'b1);
        base = n_trig;
        n_steps = 4'd3;
        rep     = 16'd0;
        expect_run(3, 0);
        fire_trigger();
        wait_trigs(base + 1, 50);
        #3 rst = 1'b1;
        #1;
        chki("arst_busy", int'(busy), 0);
        chkv("arst_delay", ch_delay, '0);
        chkv("arst_width", ch_width, '0);
        chki("arst_step", int'(step), 0);
        q.delete();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
